// File: rtl/shift_pkg.sv
// Shared constants for the serial-in/parallel-out deserializer: bit-order selectors,
// counter-width helper and the handshake state encoding.
package shift_pkg;

  localparam bit SHIFT_MSB_FIRST = 1'b1;
  localparam bit SHIFT_LSB_FIRST = 1'b0;

  typedef enum logic [0:0] {
    StCollect = 1'b0,
    StHold    = 1'b1
  } shift_state_e;

  function automatic int unsigned shift_cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-Modulus up-counter with enable, synchronous active-high clear and a
// terminal-count flag that is high while the count sits at Modulus-1.
module mod_n_counter #(
  parameter int unsigned Modulus = 4,
  parameter int unsigned Width   = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [Width-1:0] cnt,
  output logic             tc
);

  logic [Width-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = (r_cnt == Width'(Modulus - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;
  assign tc  = w_tc;

endmodule

// File: rtl/shift_sipo_deserializer.sv
// Collects a serial bit stream into N-bit words with valid/ready on both sides.
// Define SHIFT_SIPO_PARITY_EN to append an even-parity bit to each frame and expose parity_err.
module shift_sipo_deserializer
  import shift_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = SHIFT_MSB_FIRST
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sin,
  input  logic                            sin_valid,
  output logic                            sin_ready,
  output logic [N-1:0]                    q,
  output logic                            q_valid,
  input  logic                            q_ready,
`ifdef SHIFT_SIPO_PARITY_EN
  output logic                            parity_err,
`endif
  output logic [shift_cnt_width(N)-1:0]   bit_cnt
);

  localparam int unsigned CntW = shift_cnt_width(N);
`ifdef SHIFT_SIPO_PARITY_EN
  localparam int unsigned FrameLen = N + 1;
`else
  localparam int unsigned FrameLen = N;
`endif

  shift_state_e r_state, w_state_next;

  logic [N-1:0]    r_sreg;
  logic [N-1:0]    r_q;
  logic [N-1:0]    w_shift;
  logic [CntW-1:0] w_cnt;
  logic            w_tc;
  logic            w_accept;
  logic            w_complete;
  logic            w_xfer;
  logic            w_q_valid;
  logic            w_sin_ready;

  mod_n_counter #(
    .Modulus (FrameLen),
    .Width   (CntW)
  ) u_bit_cnt (
    .clk (clk),
    .clr (rst),
    .en  (w_accept),
    .cnt (w_cnt),
    .tc  (w_tc)
  );

  // Only the final bit of a frame can stall; a same-cycle q_ready frees it.
  assign w_sin_ready = !(w_tc && w_q_valid && !q_ready);
  assign w_accept    = sin_valid && w_sin_ready;
  assign w_complete  = w_accept && w_tc;
  assign w_xfer      = w_q_valid && q_ready;

  always_comb begin
    w_shift = r_sreg;
    if (MSB_FIRST) begin
      w_shift = {r_sreg[N-2:0], sin};
    end else begin
      w_shift = {sin, r_sreg[N-1:1]};
    end
  end

`ifdef SHIFT_SIPO_PARITY_EN
  logic r_parity_err;

  // The parity bit is consumed by the checker and never enters the shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg       <= '0;
      r_q          <= '0;
      r_parity_err <= 1'b0;
    end else if (w_complete) begin
      r_q          <= r_sreg;
      r_parity_err <= (^r_sreg) ^ sin;
    end else if (w_accept) begin
      r_sreg <= w_shift;
    end
  end

  assign parity_err = r_parity_err;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg <= '0;
      r_q    <= '0;
    end else if (w_accept) begin
      r_sreg <= w_shift;
      if (w_complete) begin
        r_q <= w_shift;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StCollect;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StCollect: if (w_complete) w_state_next = StHold;
      StHold:    if (w_xfer && !w_complete) w_state_next = StCollect;
      default:   w_state_next = StCollect;
    endcase
  end

  always_comb begin
    w_q_valid = 1'b0;
    unique case (r_state)
      StCollect: w_q_valid = 1'b0;
      StHold:    w_q_valid = 1'b1;
      default:   w_q_valid = 1'b0;
    endcase
  end

  assign sin_ready = w_sin_ready;
  assign q         = r_q;
  assign q_valid   = w_q_valid;
  assign bit_cnt   = w_cnt;

endmodule
